// File: rtl/cmb_evt_queue_if.sv
// cmb_evt_queue_if: sample inputs, clear, and consumer handshake
// of the event queue, bundled with master/slave views.
interface cmb_evt_queue_if #(
  parameter int TSW = 8
);
  logic           en;
  logic [3:0]     evt_in;
  logic           clr;
  logic           out_ready;
  logic           out_valid;
  logic [3:0]     out_mask;
  logic [TSW-1:0] out_time;
  logic           overflow;
  logic [7:0]     drop_cnt;

  modport master (
    output en,
    output evt_in,
    output clr,
    output out_ready,
    input  out_valid,
    input  out_mask,
    input  out_time,
    input  overflow,
    input  drop_cnt
  );

  modport slave (
    input  en,
    input  evt_in,
    input  clr,
    input  out_ready,
    output out_valid,
    output out_mask,
    output out_time,
    output overflow,
    output drop_cnt
  );
endinterface

// File: rtl/cmb_evt_queue.sv
// cmb_evt_queue: rising-edge capture of cmb outputs, timestamped
// into a show-ahead FIFO with sticky overflow and drop counter.
module cmb_evt_queue #(
  parameter int DEPTH = 4,
  parameter int TSW   = 8
) (
  input logic          clk,
  input logic          rst,
  cmb_evt_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);

  logic [3:0]     prev_q, prev_d;
  logic [TSW-1:0] ts_q, ts_d;
  logic [AW:0]    wptr_q, wptr_d;
  logic [AW:0]    rptr_q, rptr_d;
  logic           overflow_q, overflow_d;
  logic [7:0]     drop_cnt_q, drop_cnt_d;

  logic [3:0]     mask_mem_q [DEPTH];
  logic [3:0]     mask_mem_d [DEPTH];
  logic [TSW-1:0] time_mem_q [DEPTH];
  logic [TSW-1:0] time_mem_d [DEPTH];

  logic [3:0]     rise;
  logic           empty;
  logic           full;
  logic           push;
  logic           pop;
  logic           wr_en;
  logic           drop;
  logic [AW-1:0]  wr_idx;
  logic [AW-1:0]  rd_idx;

  assign wr_idx = wptr_q[AW-1:0];
  assign rd_idx = rptr_q[AW-1:0];

  // Edge detect, timestamp, occupancy and push/pop/drop decisions.
  always_comb begin
    rise   = q.en ? (q.evt_in & ~prev_q) : 4'b0000;
    prev_d = q.en ? q.evt_in : prev_q;
    ts_d   = ts_q + {{(TSW-1){1'b0}}, 1'b1};
    empty  = (wptr_q == rptr_q);
    full   = (wptr_q[AW] != rptr_q[AW]) &&
             (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    push   = |rise;
    pop    = ~empty & q.out_ready;
    wr_en  = push & (~full | pop);
    drop   = push & full & ~pop;
    wptr_d = wptr_q + {{AW{1'b0}}, wr_en};
    rptr_d = rptr_q + {{AW{1'b0}}, pop};
  end

  // Overflow/drop bookkeeping; a drop in the clear cycle survives it.
  always_comb begin
    overflow_d = overflow_q | drop;
    drop_cnt_d = drop_cnt_q;
    if (q.clr) begin
      overflow_d = drop;
      drop_cnt_d = drop ? 8'd1 : 8'd0;
    end else if (drop && drop_cnt_q != 8'hff) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  // Storage write of the new {rise, ts} entry at the tail.
  always_comb begin
    mask_mem_d = mask_mem_q;
    time_mem_d = time_mem_q;
    if (wr_en) begin
      mask_mem_d[wr_idx] = rise;
      time_mem_d[wr_idx] = ts_q;
    end
  end

  // State registers; reset empties the queue without a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q     <= '0;
      ts_q       <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mask_mem_q[i] <= '0;
        time_mem_q[i] <= '0;
      end
    end else begin
      prev_q     <= prev_d;
      ts_q       <= ts_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      mask_mem_q <= mask_mem_d;
      time_mem_q <= time_mem_d;
    end
  end

  assign q.out_valid = ~empty;
  assign q.out_mask  = empty ? 4'b0000 : mask_mem_q[rd_idx];
  assign q.out_time  = empty ? '0 : time_mem_q[rd_idx];
  assign q.overflow  = overflow_q;
  assign q.drop_cnt  = drop_cnt_q;
endmodule

// File: tb/tb_cmb_evt_queue.sv
// tb_cmb_evt_queue: directed stimulus with a scoreboard of
// expected {mask, time} entries checked by a pop monitor.
module tb_cmb_evt_queue;
  logic clk;
  logic rst;
  logic [7:0] tsm;
  int n_chk;
  int n_fail;
  logic [11:0] sb[$];

  cmb_evt_queue_if #(.TSW(8)) qif ();

  cmb_evt_queue #(.DEPTH(4), .TSW(8)) dut (
    .clk(clk),
    .rst(rst),
    .q  (qif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference timestamp: free-running count from reset release.
  always @(posedge clk or posedge rst) begin
    if (rst) tsm <= 8'd0;
    else     tsm <= tsm + 8'd1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_push(input logic [3:0] m, input logic [7:0] t);
    sb.push_back({m, t});
  endtask

  // Monitor: every accepted head entry must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && qif.out_valid && qif.out_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL pop_unexpected: got mask %0h time %0d",
                 qif.out_mask, qif.out_time);
      end else begin
        logic [11:0] e;
        e = sb.pop_front();
        chk("pop_mask", int'(qif.out_mask), int'(e[11:8]));
        chk("pop_time", int'(qif.out_time), int'(e[7:0]));
      end
    end
  end

  task automatic drain4();
    qif.out_ready = 1'b1;
    repeat (4) step();
    qif.out_ready = 1'b0;
    chk("drain_empty", int'(qif.out_valid), 0);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    qif.en = 1'b1;
    qif.evt_in = 4'b0000;
    qif.clr = 1'b0;
    qif.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", int'(qif.out_valid), 0);
    chk("rst_mask", int'(qif.out_mask), 0);
    chk("rst_time", int'(qif.out_time), 0);
    chk("rst_ovf", int'(qif.overflow), 0);
    chk("rst_drop", int'(qif.drop_cnt), 0);
    rst = 1'b0;

    // Basic latency: edge in cycle 3 visible in cycle 4.
    step();
    step();
    step();
    qif.evt_in = 4'b0101;
    exp_push(4'b0101, 8'd3);
    step();
    chk("t1_valid", int'(qif.out_valid), 1);
    chk("t1_mask", int'(qif.out_mask), 5);
    chk("t1_time", int'(qif.out_time), 3);
    qif.out_ready = 1'b1;
    step();
    qif.out_ready = 1'b0;
    chk("t1_valid_after", int'(qif.out_valid), 0);
    chk("t1_mask_after", int'(qif.out_mask), 0);
    chk("t1_time_after", int'(qif.out_time), 0);
    qif.evt_in = 4'b0000;

    // Six pulses into a 4-deep queue: two drops.
    for (int p = 0; p < 6; p++) begin
      step();
      qif.evt_in = 4'b0001;
      if (p < 4) exp_push(4'b0001, tsm);
      step();
      qif.evt_in = 4'b0000;
    end
    step();
    chk("t2_ovf", int'(qif.overflow), 1);
    chk("t2_drop", int'(qif.drop_cnt), 2);
    chk("t2_valid", int'(qif.out_valid), 1);
    drain4();

    // Full queue with simultaneous push and pop.
    for (int p = 0; p < 4; p++) begin
      step();
      qif.evt_in = 4'b0001;
      exp_push(4'b0001, tsm);
      step();
      qif.evt_in = 4'b0000;
    end
    step();
    qif.evt_in = 4'b0001;
    qif.out_ready = 1'b1;
    exp_push(4'b0001, tsm);
    step();
    qif.evt_in = 4'b0000;
    qif.out_ready = 1'b0;
    chk("t3_nodrop", int'(qif.drop_cnt), 2);
    step();
    qif.evt_in = 4'b0001;
    step();
    qif.evt_in = 4'b0000;
    step();
    chk("t3_still_full", int'(qif.drop_cnt), 3);
    drain4();

    // Enable gating keeps prev, so no re-edge.
    qif.out_ready = 1'b1;
    qif.evt_in = 4'b1111;
    exp_push(4'b1111, tsm);
    step();
    qif.en = 1'b0;
    step();
    qif.en = 1'b1;
    step();
    qif.evt_in = 4'b0000;
    step();
    qif.evt_in = 4'b0010;
    exp_push(4'b0010, tsm);
    step();
    step();
    chk("t4_empty", int'(qif.out_valid), 0);
    chk("t4_sb", sb.size(), 0);

    // Saturating drop counter and clear behaviour.
    qif.out_ready = 1'b0;
    for (int i = 0; i < 304; i++) begin
      qif.evt_in = (i % 2 == 0) ? 4'b0001 : 4'b0010;
      if (i < 4) exp_push((i % 2 == 0) ? 4'b0001 : 4'b0010, tsm);
      step();
    end
    chk("t5_sat", int'(qif.drop_cnt), 255);
    chk("t5_ovf", int'(qif.overflow), 1);
    qif.clr = 1'b1;
    step();
    qif.clr = 1'b0;
    chk("t5_clr_ovf", int'(qif.overflow), 0);
    chk("t5_clr_drop", int'(qif.drop_cnt), 0);
    qif.clr = 1'b1;
    qif.evt_in = 4'b0001;
    step();
    qif.clr = 1'b0;
    chk("t5_clrdrop_ovf", int'(qif.overflow), 1);
    chk("t5_clrdrop_cnt", int'(qif.drop_cnt), 1);
    drain4();

    // Mid-queue async reset, then timestamp wrap.
    qif.evt_in = 4'b0011;
    exp_push(4'b0010, tsm);
    step();
    qif.evt_in = 4'b0111;
    exp_push(4'b0100, tsm);
    step();
    chk("t6_pre_valid", int'(qif.out_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    sb.delete();
    chk("t6_rst_valid", int'(qif.out_valid), 0);
    chk("t6_rst_mask", int'(qif.out_mask), 0);
    chk("t6_rst_drop", int'(qif.drop_cnt), 0);
    qif.evt_in = 4'b0000;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    qif.evt_in = 4'b0001;
    exp_push(4'b0001, 8'd0);
    step();
    chk("t6_first_valid", int'(qif.out_valid), 1);
    chk("t6_first_time", int'(qif.out_time), 0);
    qif.out_ready = 1'b1;
    repeat (259) step();
    qif.evt_in = 4'b0011;
    exp_push(4'b0010, 8'd4);
    step();
    chk("t6_wrap_valid", int'(qif.out_valid), 1);
    chk("t6_wrap_mask", int'(qif.out_mask), 2);
    chk("t6_wrap_time", int'(qif.out_time), 4);
    step();
    chk("t6_end_valid", int'(qif.out_valid), 0);
    step();
    chk("final_sb", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cmb_evt_queue.md
# cmb_evt_queue

Event-capture stage directly downstream of the `cmb` combinational block. It samples the four `cmb` outputs (po0..po3) every enabled cycle and detects rising edges. Each edge set is timestamped and queued in a small show-ahead FIFO, which a consumer drains over a valid/ready handshake. Overflow is reported through a sticky flag and a saturating drop counter.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- TSW, 8, timestamp width in bits
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- en  in  1  sample enable for edge detection
- evt_in  in  4  `cmb` outputs; bit i = po<i>
- clr  in  1  synchronous clear of `overflow` and `drop_cnt`
- out_ready  in  1  consumer accepts head entry
- out_valid  out  1  FIFO non-empty
- out_mask  out  4  head entry rising-edge mask; 0 when empty
- out_time  out  TSW  head entry timestamp; 0 when empty
- overflow  out  1  sticky: at least one entry dropped since reset/clr
- drop_cnt  out  8  dropped-entry count, saturates at 255

## Operation
- Reset (async, active-high) forces the following while asserted:
  - `prev` = 0, timestamp counter `ts` = 0, FIFO empty, `overflow` = 0, `drop_cnt` = 0.
  - Outputs: `out_valid` = 0, `out_mask` = 0, `out_time` = 0.
- Timestamp: `ts` increments every cycle regardless of `en`; wraps from 2^TSW−1 to 0.
- Edge detection:
  - `rise = en ? (evt_in & ~prev) : 0`.
  - When `en` = 1, `prev` loads `evt_in`; when `en` = 0, `prev` holds.
  - After reset, an input already high on the first enabled cycle counts as a rising edge.
- Push: when `rise` ≠ 0, write the entry {`rise`, `ts`}, where `ts` is the counter value in the same cycle, before its increment. Multiple bits rising in the same cycle form one entry.
- Pop: occurs when `out_valid` & `out_ready`. Head advances at the clock edge.
- Full FIFO:
  - Push with simultaneous pop is accepted; occupancy is unchanged.
  - Push without pop drops the entry: `overflow` ← 1 and `drop_cnt` ← min(`drop_cnt`+1, 255).
- Empty FIFO: a pop request is ignored (`out_valid` = 0). There is no bypass: a push into an empty FIFO becomes visible the next cycle.
- `clr` takes effect at the clock edge:
  - `clr` alone: `overflow` ← 0 and `drop_cnt` ← 0.
  - `clr` in the same cycle as a drop: `overflow` ← 1 and `drop_cnt` ← 1.
- Occupancy is tracked with a pointer pair plus one extra wrap bit; full = pointers equal with wrap bits differing.
- `out_valid`, `out_mask`, `out_time`, `overflow` and `drop_cnt` are all registered or derived from registered state only. No combinational path from `evt_in`, `en` or `out_ready` to any output.

## Timing
- Latency: a rising edge present on `evt_in` in cycle k, with `en` = 1, is written at the end of cycle k. With the FIFO empty, `out_valid` = 1 in cycle k+1 with `out_time` = `ts`(k).
- Throughput: one push and one pop per cycle sustained. A full FIFO with `out_ready` held high never drops.
- `out_ready` may toggle freely. `out_mask` and `out_time` hold while `out_valid` & ~`out_ready`.
- Reset asserted mid-operation discards all queued entries immediately, without waiting for a clock edge. The first push after deassertion uses `ts` = 0 in the first post-reset cycle.
- `en` deasserting while `evt_in` is high, then reasserting with `evt_in` still high, produces no edge, because `prev` held 1.

## Test plan
- Reset, `en` = 1, `evt_in` 0000→0101 in cycle 3 (`ts` = 3) → cycle 4: `out_valid` = 1, `out_mask` = 0101, `out_time` = 3. Pulse `out_ready` → cycle 5: `out_valid` = 0, `out_mask` = 0, `out_time` = 0.
- `out_ready` = 0, six single-cycle edge pulses on bit 0 (separated by low cycles, `en` = 1), DEPTH = 4 → 4 entries queued with ascending timestamps, `overflow` = 1, `drop_cnt` = 2. Then drain → four entries in push order, no duplicates.
- FIFO full, same-cycle push and pop → no drop; occupancy stays 4; new entry appears after the 3 older ones.
- `evt_in` = 1111 held high, `en` toggled 1→0→1 → exactly one entry (mask 1111); later 1111→0000→0010 → one entry with mask 0010.
- Force 300 drops → `drop_cnt` = 255. `clr` with no drop that cycle → `overflow` = 0, `drop_cnt` = 0. `clr` coincident with a drop → `overflow` = 1, `drop_cnt` = 1.
- Run 260 cycles then push → `out_time` = 4 (wrap). Assert reset mid-queue, asynchronously between edges → `out_valid` = 0 immediately; after deassert, FIFO empty and `ts` restarts at 0.
